// File: rtl/cnn_layer_data_loader_pkg.sv
// Shared constants and FSM encoding for the layer-init data loader.
package cnn_para_defs;

  localparam int DATA_WIDTH              = 16;
  localparam int PARA_X                  = 3;
  localparam int PARA_Y                  = 3;
  localparam int PARA_KERNEL             = 2;
  localparam int KERNEL_SIZE_MAX         = 5;
  localparam int KERNEL_SIZE_WIDTH       = 6;
  localparam int WRITE_ADDR_WIDTH        = 3;
  localparam int WEIGHT_WRITE_ADDR_WIDTH = 5;

  localparam int FM_WORDS      = PARA_X * PARA_Y;
  localparam int WT_SLOT_WORDS = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int WT_WORDS      = PARA_KERNEL * WT_SLOT_WORDS;
  localparam int FM_BITS       = FM_WORDS * DATA_WIDTH;
  localparam int WT_BITS       = WT_WORDS * DATA_WIDTH;
  localparam int SQ_W          = 2 * KERNEL_SIZE_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FM_LOAD = 3'd1,
    FM_END  = 3'd2,
    WT_LOAD = 3'd3,
    WT_END  = 3'd4,
    FINISH  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/cnn_layer_data_loader_packer.sv
// Collects accepted words into a shadow register laid out as GROUPS regions of GROUP slots,
// filling group_len slots per region; full flags the beat that completes the last region.
module float16_word_packer
  import cnn_para_defs::*;
#(
  parameter int SLOTS  = FM_WORDS,
  parameter int GROUP  = FM_WORDS,
  parameter int GROUPS = 1,
  parameter int LEN_W  = SQ_W,
  parameter int DW     = DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                wr,
  input  logic [DW-1:0]       din,
  input  logic [LEN_W-1:0]    group_len,
  output logic                full,
  output logic [SLOTS*DW-1:0] shadow_next
);

  localparam int GW = $clog2(GROUPS + 1);

  logic [LEN_W-1:0]    j;
  logic [GW-1:0]       g;
  logic [SLOTS*DW-1:0] shadow;
  logic                group_end;
  logic                last_group;
  int                  pos;

  assign group_end  = (j == group_len - LEN_W'(1));
  assign last_group = (g == GW'(GROUPS - 1));
  assign full       = wr && group_end && last_group;

  // Next shadow includes the word arriving this beat so a publish sees the complete line
  always_comb begin
    shadow_next = shadow;
    pos         = int'(g) * GROUP + int'(j);
    for (int s = 0; s < SLOTS; s++) begin
      if (wr && s == pos) shadow_next[s*DW +: DW] = din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      j      <= '0;
      g      <= '0;
    end else if (clear) begin
      shadow <= '0;
      j      <= '0;
      g      <= '0;
    end else if (wr) begin
      shadow <= shadow_next;
      if (group_end) begin
        j <= '0;
        g <= last_group ? '0 : g + GW'(1);
      end else begin
        j <= j + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_layer_data_loader.sv
// Streams float16 words into feature-map lines and weight slices for the layer compute block.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of all accepted words.
module cnn_layer_data_loader
  import cnn_para_defs::*;
(
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [KERNEL_SIZE_WIDTH-1:0]                   kernel_size,
  input  logic [WRITE_ADDR_WIDTH:0]                      fm_line_num,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH:0]               weight_slice_num,
  input  logic [DATA_WIDTH-1:0]                          s_data,
  input  logic                                           s_valid,
  output logic                                           s_ready,
  output logic [FM_BITS-1:0]                             init_fm_data,
  output logic [WRITE_ADDR_WIDTH-1:0]                    write_fm_data_addr,
  output logic                                           init_fm_data_done,
  output logic [WT_BITS-1:0]                             weight_data,
  output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr,
  output logic                                           weight_data_done,
  output logic                                           busy,
  output logic                                           load_done,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]                          checksum,
`endif
  output logic                                           cfg_err
);

  localparam logic [WRITE_ADDR_WIDTH:0]        LINE_ONE  = 1;
  localparam logic [WEIGHT_WRITE_ADDR_WIDTH:0] SLICE_ONE = 1;

  loader_state_t                    state, state_nxt;
  logic [KERNEL_SIZE_WIDTH-1:0]     ks_q;
  logic [WRITE_ADDR_WIDTH:0]        fm_num_q, line_cnt;
  logic [WEIGHT_WRITE_ADDR_WIDTH:0] wt_num_q, slice_cnt;
  logic [SQ_W-1:0]                  ks_sq;
  logic                             cfg_ok, start_acc, acc, fm_wr, wt_wr;
  logic                             fm_full, wt_full, fm_last, wt_last;
  logic [FM_BITS-1:0]               fm_next;
  logic [WT_BITS-1:0]               wt_next;

  assign cfg_ok    = (kernel_size != '0) && (kernel_size <= KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX));
  assign start_acc = (state == IDLE) && start && cfg_ok;
  assign s_ready   = (state == FM_LOAD) || (state == WT_LOAD);
  assign acc       = s_valid && s_ready;
  assign fm_wr     = acc && (state == FM_LOAD);
  assign wt_wr     = acc && (state == WT_LOAD);
  assign fm_last   = (line_cnt + LINE_ONE) == fm_num_q;
  assign wt_last   = (slice_cnt + SLICE_ONE) == wt_num_q;
  assign ks_sq     = SQ_W'(ks_q) * SQ_W'(ks_q);
  assign busy      = (state == FM_LOAD) || (state == FM_END) ||
                     (state == WT_LOAD) || (state == WT_END);
  assign load_done = (state == FINISH);

  float16_word_packer #(
    .SLOTS(FM_WORDS), .GROUP(FM_WORDS), .GROUPS(1), .LEN_W(SQ_W), .DW(DATA_WIDTH)
  ) u_fm_packer (
    .clk(clk), .rst(rst), .clear(start_acc), .wr(fm_wr), .din(s_data),
    .group_len(SQ_W'(FM_WORDS)), .full(fm_full), .shadow_next(fm_next)
  );

  float16_word_packer #(
    .SLOTS(WT_WORDS), .GROUP(WT_SLOT_WORDS), .GROUPS(PARA_KERNEL), .LEN_W(SQ_W), .DW(DATA_WIDTH)
  ) u_wt_packer (
    .clk(clk), .rst(rst), .clear(start_acc), .wr(wt_wr), .din(s_data),
    .group_len(ks_sq), .full(wt_full), .shadow_next(wt_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_acc) begin
          if (fm_line_num != '0)           state_nxt = FM_LOAD;
          else if (weight_slice_num != '0) state_nxt = WT_LOAD;
          else                             state_nxt = FINISH;
        end
      end
      FM_LOAD: if (fm_full && fm_last) state_nxt = FM_END;
      FM_END:  state_nxt = (wt_num_q == '0) ? FINISH : WT_LOAD;
      WT_LOAD: if (wt_full && wt_last) state_nxt = WT_END;
      WT_END:  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      cfg_err                <= 1'b0;
      ks_q                   <= '0;
      fm_num_q               <= '0;
      wt_num_q               <= '0;
      line_cnt               <= '0;
      slice_cnt              <= '0;
      init_fm_data           <= '0;
      write_fm_data_addr     <= '0;
      init_fm_data_done      <= 1'b1;
      weight_data            <= '0;
      write_weight_data_addr <= '0;
      weight_data_done       <= 1'b1;
    end else begin
      state   <= state_nxt;
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (start_acc) begin
        ks_q      <= kernel_size;
        fm_num_q  <= fm_line_num;
        wt_num_q  <= weight_slice_num;
        line_cnt  <= '0;
        slice_cnt <= '0;
      end
      // Publishes are atomic: data, address and done flag all change on the same edge
      if (fm_wr && fm_full) begin
        init_fm_data       <= fm_next;
        write_fm_data_addr <= line_cnt[WRITE_ADDR_WIDTH-1:0];
        init_fm_data_done  <= 1'b0;
        line_cnt           <= line_cnt + LINE_ONE;
      end
      if (state == FM_END) init_fm_data_done <= 1'b1;
      if (wt_wr && wt_full) begin
        weight_data            <= wt_next;
        write_weight_data_addr <= {PARA_KERNEL{slice_cnt[WEIGHT_WRITE_ADDR_WIDTH-1:0]}};
        weight_data_done       <= 1'b0;
        slice_cnt              <= slice_cnt + SLICE_ONE;
      end
      if (state == WT_END) weight_data_done <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           checksum <= '0;
    else if (start_acc) checksum <= '0;
    else if (acc)       checksum <= checksum ^ s_data;
  end
`endif

endmodule

// File: tb/tb_cnn_layer_data_loader.sv
// Bench for cnn_layer_data_loader: directed and randomized loads against a word-queue model.
module tb_cnn_layer_data_loader;
  import cnn_para_defs::*;

  localparam int FMW  = FM_BITS;
  localparam int WTW  = WT_BITS;
  localparam int WAW  = WRITE_ADDR_WIDTH;
  localparam int WADW = WEIGHT_WRITE_ADDR_WIDTH * PARA_KERNEL;

  logic                             clk = 1'b0;
  logic                             rst = 1'b0;
  logic                             start = 1'b0;
  logic [KERNEL_SIZE_WIDTH-1:0]     kernel_size = '0;
  logic [WAW:0]                     fm_line_num = '0;
  logic [WEIGHT_WRITE_ADDR_WIDTH:0] weight_slice_num = '0;
  logic [DATA_WIDTH-1:0]            s_data = '0;
  logic                             s_valid = 1'b0;
  logic                             s_ready;
  logic [FMW-1:0]                   init_fm_data;
  logic [WAW-1:0]                   write_fm_data_addr;
  logic                             init_fm_data_done;
  logic [WTW-1:0]                   weight_data;
  logic [WADW-1:0]                  write_weight_data_addr;
  logic                             weight_data_done;
  logic                             busy, load_done, cfg_err;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]            checksum;
`endif

  cnn_layer_data_loader dut (
    .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
    .fm_line_num(fm_line_num), .weight_slice_num(weight_slice_num),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .init_fm_data(init_fm_data), .write_fm_data_addr(write_fm_data_addr),
    .init_fm_data_done(init_fm_data_done), .weight_data(weight_data),
    .write_weight_data_addr(write_weight_data_addr), .weight_data_done(weight_data_done),
    .busy(busy), .load_done(load_done),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Publish monitor: a new publish is a done flag falling or the address moving while done is low
  logic [FMW-1:0]  fm_q[$];
  logic [WAW-1:0]  fm_aq[$];
  int              fm_cq[$];
  logic [WTW-1:0]  wt_q[$];
  logic [WADW-1:0] wt_aq[$];
  int              wt_cq[$];
  int              fm_rise = -1, wt_rise = -1, ld_cnt = 0, glitch = 0;
  logic            p_fm_done = 1'b1, p_wt_done = 1'b1;
  logic [FMW-1:0]  p_fm_data = '0;
  logic [WTW-1:0]  p_wt_data = '0;
  logic [WAW-1:0]  p_fm_addr = '0;
  logic [WADW-1:0] p_wt_addr = '0;

  always @(negedge clk) begin
    if (!init_fm_data_done && (p_fm_done || write_fm_data_addr != p_fm_addr)) begin
      fm_q.push_back(init_fm_data);
      fm_aq.push_back(write_fm_data_addr);
      fm_cq.push_back(cyc);
    end else if (!init_fm_data_done && init_fm_data != p_fm_data) begin
      glitch <= glitch + 1;
    end
    if (!weight_data_done && (p_wt_done || write_weight_data_addr != p_wt_addr)) begin
      wt_q.push_back(weight_data);
      wt_aq.push_back(write_weight_data_addr);
      wt_cq.push_back(cyc);
    end else if (!weight_data_done && weight_data != p_wt_data) begin
      glitch <= glitch + 1;
    end
    if (init_fm_data_done && !p_fm_done) fm_rise <= cyc;
    if (weight_data_done && !p_wt_done)  wt_rise <= cyc;
    if (load_done) ld_cnt <= ld_cnt + 1;
    p_fm_done <= init_fm_data_done;
    p_wt_done <= weight_data_done;
    p_fm_data <= init_fm_data;
    p_wt_data <= weight_data;
    p_fm_addr <= write_fm_data_addr;
    p_wt_addr <= write_weight_data_addr;
  end

  int total = 0;
  int bad = 0;
  logic [DATA_WIDTH-1:0] words[$];

  task automatic check(input string tag, input logic [WTW-1:0] got, input logic [WTW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [FMW-1:0] exp_line(input int base);
    logic [FMW-1:0] r = '0;
    for (int i = 0; i < FM_WORDS; i++) r[i*DATA_WIDTH +: DATA_WIDTH] = words[base + i];
    return r;
  endfunction

  function automatic logic [WTW-1:0] exp_slice(input int base, input int ks);
    logic [WTW-1:0] r = '0;
    for (int k = 0; k < PARA_KERNEL; k++)
      for (int j = 0; j < ks * ks; j++)
        r[(k*WT_SLOT_WORDS + j)*DATA_WIDTH +: DATA_WIDTH] = words[base + k*ks*ks + j];
    return r;
  endfunction

  // mode 0: valid held, 1: valid toggles each cycle, 2: random valid
  task automatic drive(input int n, input int mode, output bit ok);
    int   idx = 0;
    int   guard = 0;
    logic tg = 1'b1;
    logic v, r;
    while (idx < n && guard < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tg; tg = ~tg; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = v ? words[idx] : DATA_WIDTH'($urandom);
      r = s_ready;
      @(posedge clk);
      if (v && r) idx++;
      step();
      guard++;
    end
    s_valid = 1'b0;
    ok = (idx == n);
  endtask

  task automatic run_load(input int ks, input int fm_n, input int wt_n, input int mode, input string tag);
    int n = fm_n * FM_WORDS + wt_n * PARA_KERNEL * ks * ks;
    int fb = fm_q.size();
    int wb = wt_q.size();
    int lb = ld_cnt;
    int g = 0;
    bit ok;
    logic [DATA_WIDTH-1:0] x = '0;
    kernel_size      = KERNEL_SIZE_WIDTH'(ks);
    fm_line_num      = (WAW+1)'(fm_n);
    weight_slice_num = (WEIGHT_WRITE_ADDR_WIDTH+1)'(wt_n);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, WTW'(busy), WTW'(n != 0));
    drive(n, mode, ok);
    check({tag, "_beats"}, WTW'(ok), WTW'(1));
    while (ld_cnt == lb && g < 60) begin step(); g++; end
    repeat (3) step();
    check({tag, "_load_done_pulses"}, WTW'(ld_cnt - lb), WTW'(1));
    check({tag, "_fm_lines"}, WTW'(fm_q.size() - fb), WTW'(fm_n));
    for (int i = 0; i < fm_n && fb + i < fm_q.size(); i++) begin
      check($sformatf("%s_fm_data%0d", tag, i), WTW'(fm_q[fb + i]), WTW'(exp_line(i * FM_WORDS)));
      check($sformatf("%s_fm_addr%0d", tag, i), WTW'(fm_aq[fb + i]), WTW'(i));
    end
    if (fm_n > 0 && fm_q.size() == fb + fm_n)
      check({tag, "_fm_done_rise"}, WTW'(fm_rise), WTW'(fm_cq[fb + fm_n - 1] + 1));
    check({tag, "_wt_slices"}, WTW'(wt_q.size() - wb), WTW'(wt_n));
    for (int s = 0; s < wt_n && wb + s < wt_q.size(); s++) begin
      check($sformatf("%s_wt_data%0d", tag, s), wt_q[wb + s],
            exp_slice(fm_n * FM_WORDS + s * PARA_KERNEL * ks * ks, ks));
      check($sformatf("%s_wt_addr%0d", tag, s), WTW'(wt_aq[wb + s]),
            WTW'({PARA_KERNEL{WEIGHT_WRITE_ADDR_WIDTH'(s)}}));
    end
    if (wt_n > 0 && wt_q.size() == wb + wt_n)
      check({tag, "_wt_done_rise"}, WTW'(wt_rise), WTW'(wt_cq[wb + wt_n - 1] + 1));
    check({tag, "_idle_busy"}, WTW'(busy), WTW'(0));
    check({tag, "_idle_done"}, WTW'({init_fm_data_done, weight_data_done}), WTW'(2'b11));
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < n; i++) x ^= words[i];
    check({tag, "_checksum"}, WTW'(checksum), WTW'(x));
`endif
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    #1;
    check("rst_fm_done_in_reset", WTW'(init_fm_data_done), WTW'(1));
    rst = 1'b1;
    step();
    check("rst_fm_data", WTW'(init_fm_data), WTW'(0));
    check("rst_fm_addr", WTW'(write_fm_data_addr), WTW'(0));
    check("rst_fm_done", WTW'(init_fm_data_done), WTW'(1));
    check("rst_wt_data", weight_data, WTW'(0));
    check("rst_wt_addr", WTW'(write_weight_data_addr), WTW'(0));
    check("rst_wt_done", WTW'(weight_data_done), WTW'(1));
    check("rst_ctrl", WTW'({s_ready, busy, load_done, cfg_err}), WTW'(0));

    // Two FM lines, valid held high
    words.delete();
    for (int n = 1; n <= 18; n++) words.push_back(DATA_WIDTH'(n));
    run_load(3, 2, 0, 0, "s1");

    // One weight slice, kernel 3x3, no FM phase
    words.delete();
    for (int n = 0; n < 18; n++) words.push_back(DATA_WIDTH'(16'h3C00 + n));
    run_load(3, 0, 1, 0, "s2");

    // Same as the first load with valid toggling
    words.delete();
    for (int n = 1; n <= 18; n++) words.push_back(DATA_WIDTH'(n));
    run_load(3, 2, 0, 1, "s3");

    // Rejected kernel sizes
    for (int t = 0; t < 2; t++) begin
      kernel_size = (t == 0) ? KERNEL_SIZE_WIDTH'(0) : KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX + 1);
      fm_line_num = 1;
      weight_slice_num = 1;
      start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("cfg_err_pulse%0d", t), WTW'(cfg_err), WTW'(1));
      check($sformatf("cfg_busy%0d", t), WTW'({busy, s_ready}), WTW'(0));
      step();
      check($sformatf("cfg_err_clear%0d", t), WTW'({cfg_err, busy, s_ready}), WTW'(0));
    end

    // Both counts zero goes straight to FINISH
    words.delete();
    run_load(2, 0, 0, 0, "s_empty");

    // Reset in the middle of a line discards the partial shadow
    words.delete();
    for (int n = 0; n < FM_WORDS; n++) words.push_back(DATA_WIDTH'($urandom));
    kernel_size = 3;
    fm_line_num = 1;
    weight_slice_num = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    drive(5, 0, ok);
    check("mid_rst_beats", WTW'(ok), WTW'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_fm_data", WTW'(init_fm_data), WTW'(0));
    check("mid_rst_wt_data", weight_data, WTW'(0));
    check("mid_rst_done", WTW'({init_fm_data_done, weight_data_done}), WTW'(2'b11));
    check("mid_rst_ctrl", WTW'({s_ready, busy, load_done}), WTW'(0));
    step();
    rst = 1'b1;
    step();
    words.delete();
    for (int n = 0; n < FM_WORDS; n++) words.push_back(DATA_WIDTH'($urandom));
    run_load(3, 1, 0, 0, "s_after_rst");

    // Randomized configurations and stalls
    for (int r = 0; r < 8; r++) begin
      int ks = $urandom_range(1, KERNEL_SIZE_MAX);
      int fn = $urandom_range(0, 3);
      int wn = $urandom_range(0, 3);
      words.delete();
      for (int n = 0; n < fn * FM_WORDS + wn * PARA_KERNEL * ks * ks; n++)
        words.push_back(DATA_WIDTH'($urandom));
      run_load(ks, fn, wn, 2, $sformatf("rnd%0d", r));
    end

    check("no_change_between_publishes", WTW'(glitch), WTW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
